// File: rtl/analog_tx_buffered.sv
// Spin snapshot transmitter: gated capture, runtime-depth synchronizer chain,
// and a small snapshot FIFO with saturating overflow accounting.
module analog_tx_buffered #(
    parameter int NUM_SPIN       = 256,
    parameter int SYNC_MAX_DEPTH = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int CNT_W          = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  en_i,
    input  logic                                  cfg_en_i,
    input  logic [$clog2(SYNC_MAX_DEPTH+1)-1:0]   sync_depth_i,
    input  logic                                  clear_i,
    input  logic [NUM_SPIN-1:0]                   spin_i,
    input  logic                                  cmpt_finish_i,
    output logic                                  spin_valid_o,
    input  logic                                  spin_ready_i,
    output logic [NUM_SPIN-1:0]                   spin_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_level_o,
    output logic [CNT_W-1:0]                      overflow_cnt_o,
    output logic                                  overflow_o,
    output logic                                  cfg_reject_o,
    output logic                                  idle_o
);

    localparam int DW = $clog2(SYNC_MAX_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    logic [DW-1:0]             depth_reg;
    logic [SYNC_MAX_DEPTH-1:0] pipe_v;
    logic [NUM_SPIN-1:0]       pipe_d [SYNC_MAX_DEPTH];
    logic [NUM_SPIN-1:0]       mem    [FIFO_DEPTH];
    logic [AW:0]               wptr, rptr;

    logic [NUM_SPIN-1:0] gated;
    logic [NUM_SPIN-1:0] src_d;
    logic                src_v;
    logic                active;
    logic                fifo_empty, fifo_full;
    logic                push, pop, drop;
    logic [DW-1:0]       cfg_depth;

    assign gated  = spin_i & {NUM_SPIN{cmpt_finish_i}};
    assign active = en_i & ~clear_i;

    // Write source is the stage selected by depth_reg; depth 0 bypasses the chain.
    always_comb begin
        src_v = cmpt_finish_i;
        src_d = gated;
        for (int k = 1; k <= SYNC_MAX_DEPTH; k++) begin
            if (depth_reg == DW'(k)) begin
                src_v = pipe_v[k-1];
                src_d = pipe_d[k-1];
            end
        end
    end

    assign fifo_empty   = (wptr == rptr);
    assign fifo_full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop          = active & ~fifo_empty & spin_ready_i;
    assign push         = active & src_v & (~fifo_full | pop);
    assign drop         = active & src_v & fifo_full & ~pop;
    assign spin_valid_o = ~fifo_empty;
    assign spin_o       = mem[rptr[AW-1:0]];
    assign fifo_level_o = LW'(wptr - rptr);
    assign idle_o       = ~|pipe_v & fifo_empty;
    assign cfg_depth    = (sync_depth_i > DW'(SYNC_MAX_DEPTH)) ? DW'(SYNC_MAX_DEPTH) : sync_depth_i;

    // Stages past the configured depth never go valid, so idle_o is not held off by them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_v <= '0;
            // NOTE: vector storage is reset too so no stale snapshot survives a reset.
            for (int k = 0; k < SYNC_MAX_DEPTH; k++) pipe_d[k] <= '0;
        end else if (!active) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= cmpt_finish_i && (depth_reg != '0);
            if (cmpt_finish_i) pipe_d[0] <= gated;
            for (int k = 1; k < SYNC_MAX_DEPTH; k++) begin
                pipe_v[k] <= pipe_v[k-1] && (DW'(k) < depth_reg);
                if (pipe_v[k-1]) pipe_d[k] <= pipe_d[k-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
        end else if (!active) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                mem[wptr[AW-1:0]] <= src_d;
                wptr              <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    // Counters, sticky flags and depth hold while disabled; clear wins over config.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            depth_reg      <= DW'(SYNC_MAX_DEPTH);
            overflow_cnt_o <= '0;
            overflow_o     <= 1'b0;
            cfg_reject_o   <= 1'b0;
        end else if (clear_i) begin
            overflow_cnt_o <= '0;
            overflow_o     <= 1'b0;
            cfg_reject_o   <= 1'b0;
        end else if (en_i) begin
            if (drop) begin
                overflow_o <= 1'b1;
                if (overflow_cnt_o != {CNT_W{1'b1}}) overflow_cnt_o <= overflow_cnt_o + 1'b1;
            end
            if (cfg_en_i) begin
                if (idle_o) depth_reg    <= cfg_depth;
                else        cfg_reject_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_analog_tx_buffered.sv
// Directed bench for analog_tx_buffered: latency, clamping, overflow, concurrent
// push/pop when full, config rejection, disable/clear and asynchronous reset.
module tb_analog_tx_buffered;

    localparam int NUM_SPIN = 256;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b0;
    logic                en_i = 1'b0;
    logic                cfg_en_i = 1'b0;
    logic [2:0]          sync_depth_i = '0;
    logic                clear_i = 1'b0;
    logic [NUM_SPIN-1:0] spin_i = '0;
    logic                cmpt_finish_i = 1'b0;
    logic                spin_valid_o;
    logic                spin_ready_i = 1'b0;
    logic [NUM_SPIN-1:0] spin_o;
    logic [2:0]          fifo_level_o;
    logic [7:0]          overflow_cnt_o;
    logic                overflow_o;
    logic                cfg_reject_o;
    logic                idle_o;

    int n_vec = 0;
    int n_err = 0;

    analog_tx_buffered #(
        .NUM_SPIN(NUM_SPIN), .SYNC_MAX_DEPTH(4), .FIFO_DEPTH(4), .CNT_W(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .cfg_en_i(cfg_en_i),
        .sync_depth_i(sync_depth_i), .clear_i(clear_i), .spin_i(spin_i),
        .cmpt_finish_i(cmpt_finish_i), .spin_valid_o(spin_valid_o),
        .spin_ready_i(spin_ready_i), .spin_o(spin_o), .fifo_level_o(fifo_level_o),
        .overflow_cnt_o(overflow_cnt_o), .overflow_o(overflow_o),
        .cfg_reject_o(cfg_reject_o), .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [NUM_SPIN-1:0] pat(input logic [7:0] b);
        return {32{b}};
    endfunction

    task automatic chk(input string tag, input logic [NUM_SPIN-1:0] obs,
                       input logic [NUM_SPIN-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cfg(input logic [2:0] d);
        cfg_en_i = 1'b1; sync_depth_i = d;
        tick();
        cfg_en_i = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] b);
        spin_i = pat(b); cmpt_finish_i = 1'b1;
        tick();
        spin_i = '0; cmpt_finish_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 rst_i = 1'b1;
        #2;
        chk("rst_valid", spin_valid_o, 0);
        chk("rst_spin", spin_o, 0);
        chk("rst_level", fifo_level_o, 0);
        chk("rst_cnt", overflow_cnt_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_rej", cfg_reject_o, 0);
        chk("rst_idle", idle_o, 1);
        tick(); tick();
        rst_i = 1'b0; en_i = 1'b1;
        tick();

        // 1: depth 2, latency d+1, pop on arrival
        cfg(3'd2);
        spin_ready_i = 1'b1;
        pulse(8'hA5);
        chk("t1_idle_busy", idle_o, 0);
        tick();
        chk("t1_valid_early", spin_valid_o, 0);
        tick();
        chk("t1_valid", spin_valid_o, 1);
        chk("t1_data", spin_o, pat(8'hA5));
        chk("t1_level1", fifo_level_o, 1);
        tick();
        chk("t1_level0", fifo_level_o, 0);
        chk("t1_idle", idle_o, 1);

        // 2: depth 0, gating without a pulse, clamp 7 -> 4
        cfg(3'd0);
        spin_i = pat(8'h3C);
        tick();
        spin_i = '0;
        chk("t2_gated", spin_valid_o, 0);
        pulse(8'h5A);
        chk("t2_d0_valid", spin_valid_o, 1);
        chk("t2_d0_data", spin_o, pat(8'h5A));
        tick();
        chk("t2_d0_drain", fifo_level_o, 0);
        cfg(3'd7);
        pulse(8'hC3);
        tick(); tick(); tick();
        chk("t2_clamp_early", spin_valid_o, 0);
        tick();
        chk("t2_clamp_valid", spin_valid_o, 1);
        chk("t2_clamp_data", spin_o, pat(8'hC3));
        tick();
        chk("t2_clamp_idle", idle_o, 1);

        // 3: six pulses into a 4-deep FIFO with consumer stalled
        spin_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pulse(8'h10 + 8'(i));
            tick();
        end
        repeat (6) tick();
        chk("t3_level", fifo_level_o, 4);
        chk("t3_cnt", overflow_cnt_o, 2);
        chk("t3_ovf", overflow_o, 1);
        spin_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_order%0d", i), spin_o, pat(8'h10 + 8'(i)));
            tick();
        end
        chk("t3_empty", fifo_level_o, 0);

        // 4: full FIFO, pop and push in the same cycle
        spin_ready_i = 1'b0;
        cfg(3'd0);
        for (int i = 0; i < 4; i++) pulse(8'h40 + 8'(i));
        chk("t4_full", fifo_level_o, 4);
        spin_ready_i = 1'b1;
        pulse(8'h44);
        chk("t4_level_held", fifo_level_o, 4);
        chk("t4_cnt_held", overflow_cnt_o, 2);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("t4_order%0d", i), spin_o, pat(8'h40 + 8'(i)));
            tick();
        end
        chk("t4_empty", fifo_level_o, 0);

        // 5: config write refused while a snapshot is in flight
        cfg(3'd3);
        pulse(8'h77);
        chk("t5_busy", idle_o, 0);
        cfg(3'd1);
        chk("t5_reject", cfg_reject_o, 1);
        chk("t5_valid_t2", spin_valid_o, 0);
        tick();
        chk("t5_valid_t3", spin_valid_o, 0);
        tick();
        chk("t5_valid_t4", spin_valid_o, 1);
        chk("t5_data", spin_o, pat(8'h77));
        tick();
        chk("t5_idle", idle_o, 1);
        cfg(3'd1);
        pulse(8'h88);
        chk("t5_new_early", spin_valid_o, 0);
        tick();
        chk("t5_new_valid", spin_valid_o, 1);
        chk("t5_rej_sticky", cfg_reject_o, 1);
        tick();

        // 6: disable with queued entries, then clear
        spin_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) pulse(8'h90 + 8'(i));
        tick(); tick();
        chk("t6_level3", fifo_level_o, 3);
        en_i = 1'b0;
        tick();
        chk("t6_valid_off", spin_valid_o, 0);
        chk("t6_level_off", fifo_level_o, 0);
        chk("t6_cnt_held", overflow_cnt_o, 2);
        chk("t6_ovf_held", overflow_o, 1);
        chk("t6_rej_held", cfg_reject_o, 1);
        pulse(8'hEE);
        chk("t6_dis_idle", idle_o, 1);
        en_i = 1'b1;
        clear_i = 1'b1;
        pulse(8'hDD);
        clear_i = 1'b0;
        chk("t6_clr_cnt", overflow_cnt_o, 0);
        chk("t6_clr_ovf", overflow_o, 0);
        chk("t6_clr_rej", cfg_reject_o, 0);
        tick(); tick();
        chk("t6_clr_discard", spin_valid_o, 0);

        // Asynchronous reset mid-operation
        cfg(3'd0);
        pulse(8'hF0);
        chk("rst2_pre", fifo_level_o, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("rst2_level", fifo_level_o, 0);
        chk("rst2_spin", spin_o, 0);
        chk("rst2_idle", idle_o, 1);
        tick();
        rst_i = 1'b0;
        pulse(8'h12);
        tick(); tick(); tick();
        chk("rst2_depth_early", spin_valid_o, 0);
        tick();
        chk("rst2_depth_valid", spin_valid_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/analog_tx_buffered.md
Name: analog_tx_buffered

Overview:
Next-generation analog-to-digital spin transmitter. It samples the spin vector from the analog macro on each computation-finish pulse and passes it through a runtime-configurable synchronizer chain of depth 0..SYNC_MAX_DEPTH. Each synchronized snapshot goes into a small snapshot FIFO, so back-to-back finish pulses are not lost while the digital side stalls. Overflow drops are counted and flagged. It sits between the analog macro wrapper and the digital spin consumer, replacing the single-register TX.

Parameters:
NUM_SPIN, 256, spin vector width
SYNC_MAX_DEPTH, 4, max synchronizer stages (>=1)
FIFO_DEPTH, 4, snapshot FIFO entries (power of 2, >=2)
CNT_W, 8, overflow counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
en_i  in  1  block enable
cfg_en_i  in  1  config write strobe
sync_depth_i  in  $clog2(SYNC_MAX_DEPTH+1)  requested synchronizer depth
clear_i  in  1  sync clear of FIFO, pipeline, counters, flags
spin_i  in  NUM_SPIN  raw spins from analog macro
cmpt_finish_i  in  1  one-cycle finish pulse
spin_valid_o  out  1  FIFO non-empty
spin_ready_i  in  1  consumer ready
spin_o  out  NUM_SPIN  FIFO head snapshot
fifo_level_o  out  $clog2(FIFO_DEPTH+1)  occupied entries
overflow_cnt_o  out  CNT_W  dropped snapshots, saturating
overflow_o  out  1  sticky: at least one drop
cfg_reject_o  out  1  sticky: config write refused while busy
idle_o  out  1  pipeline and FIFO empty

Behaviour:
- Interface: one clock (clk_i); reset is asynchronous and active-high (rst_i).
- Reset values: depth_reg=SYNC_MAX_DEPTH, pipeline empty, FIFO empty, spin_valid_o=0, spin_o=0, fifo_level_o=0, overflow_cnt_o=0, overflow_o=0, cfg_reject_o=0, idle_o=1.
- Input gating: the captured vector is spin_i AND cmpt_finish_i, bitwise, so zeros enter when there is no pulse.
- Config: applied when en_i & cfg_en_i & idle_o. A value > SYNC_MAX_DEPTH clamps to SYNC_MAX_DEPTH. If cfg_en_i & en_i & !idle_o, the write is ignored and cfg_reject_o is set.
- Pipeline: SYNC_MAX_DEPTH stages. Each stage holds a valid bit plus a vector and advances every cycle while en_i=1. Stage k loads only when valid bit k-1 is set, and its valid bit copies valid bit k-1. With depth d, the stage-d output is the FIFO write source. With d=0, the gated input is the write source directly.
- Latency: pulse at cycle t with FIFO empty and ready ignored gives spin_valid_o=1 at t+d+1 and spin_o=spin_i(t).
- FIFO write: on write-source valid when not full, or when full with a pop in the same cycle (simultaneous push+pop while full is legal; level unchanged).
- FIFO read: pop on spin_valid_o & spin_ready_i. spin_o is the head, registered storage, stable while valid and not popped. Empty plus push gives valid next cycle; there is no same-cycle bypass.
- Overflow: a write source arrives, the FIFO is full and there is no pop. The new snapshot is dropped (oldest is kept), overflow_cnt increments saturating at 2^CNT_W-1, and overflow_o is set.
- en_i=0: synchronously flush pipeline valid bits and FIFO pointers, ignore cmpt_finish_i, cfg_en_i and handshakes, and hold counters and flags.
- clear_i (priority over all but reset): flush pipeline and FIFO, zero overflow_cnt_o, overflow_o and cfg_reject_o. A pulse in the same cycle is discarded.
- idle_o = no pipeline valid bit set & FIFO empty, combinational.
- Wrap-around: read/write pointers of $clog2(FIFO_DEPTH)+1 bits. Full = MSBs differ and LSBs equal.
- Reset mid-operation: all state returns to reset values asynchronously, and no partial snapshot survives.

Test Plan:
1. Reset, then depth=2 config, then a pulse at cycle 10 with spin_i=0xA5..A5 and ready=1 -> valid rises at cycle 13, spin_o=0xA5..A5, popped at cycle 13, level returns to 0.
2. depth=0 with a pulse -> valid exactly 1 cycle later. Config sync_depth_i=7 -> clamps to 4, and a pulse then yields valid at +5.
3. ready=0 with 6 pulses 2 cycles apart, FIFO_DEPTH=4 -> level=4, overflow_cnt=2, overflow_o=1. Draining gives the first 4 snapshots in order.
4. FIFO full with ready=1 and an arriving snapshot in the same cycle -> level stays 4, no overflow increment, new snapshot at tail.
5. Config write while one snapshot is in flight -> cfg_reject_o=1, depth unchanged. A later write when idle is accepted.
6. en_i dropped with 3 entries queued -> valid=0 and level=0 next cycle, counters held. clear_i -> overflow_cnt=0 and flags clear.
